iob2axil: RTL and testbench

Bridge from an IOb-bus slave port to an AXI4-Lite master port. It is the initiator-side counterpart of the peripheral AXI-Lite-to-IOb bridge. It lets an IOb master, such as a DMA engine or debug unit, reach AXI-Lite targets through the system interconnect. The bridge carries one transaction at a time. The request is registered on acceptance, replayed onto the AXI channels with independent AW/W handshakes, and the response is returned on the IOb side.

---
 rtl/iob2axil_if.sv | 66 ++++++
 rtl/iob2axil.sv | 118 +++++++++++
 tb/tb_iob2axil.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob2axil_if.sv
// IOb-slave / AXI4-Lite-master signal bundle for the iob2axil bridge.
// The bridge connects through 'slave'; the IOb initiator and the AXI target use 'master'.
interface iob2axil_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int STRB_W = DATA_W / 8;

   logic              iob_avalid;
   logic [ADDR_W-1:0] iob_addr;
   logic [DATA_W-1:0] iob_wdata;
   logic [STRB_W-1:0] iob_wstrb;
   logic              iob_rvalid;
   logic [DATA_W-1:0] iob_rdata;
   logic              iob_ready;

   logic [ADDR_W-1:0] axil_awaddr;
   logic [2:0]        axil_awprot;
   logic              axil_awvalid;
   logic              axil_awready;
   logic [DATA_W-1:0] axil_wdata;
   logic [STRB_W-1:0] axil_wstrb;
   logic              axil_wvalid;
   logic              axil_wready;
   logic [1:0]        axil_bresp;
   logic              axil_bvalid;
   logic              axil_bready;
   logic [ADDR_W-1:0] axil_araddr;
   logic [2:0]        axil_arprot;
   logic              axil_arvalid;
   logic              axil_arready;
   logic [DATA_W-1:0] axil_rdata;
   logic [1:0]        axil_rresp;
   logic              axil_rvalid;
   logic              axil_rready;

   modport slave (
      input  iob_avalid, iob_addr, iob_wdata, iob_wstrb,
      output iob_rvalid, iob_rdata, iob_ready,
      output axil_awaddr, axil_awprot, axil_awvalid,
      input  axil_awready,
      output axil_wdata, axil_wstrb, axil_wvalid,
      input  axil_wready,
      input  axil_bresp, axil_bvalid,
      output axil_bready,
      output axil_araddr, axil_arprot, axil_arvalid,
      input  axil_arready,
      input  axil_rdata, axil_rresp, axil_rvalid,
      output axil_rready
   );

   modport master (
      output iob_avalid, iob_addr, iob_wdata, iob_wstrb,
      input  iob_rvalid, iob_rdata, iob_ready,
      input  axil_awaddr, axil_awprot, axil_awvalid,
      output axil_awready,
      input  axil_wdata, axil_wstrb, axil_wvalid,
      output axil_wready,
      output axil_bresp, axil_bvalid,
      input  axil_bready,
      input  axil_araddr, axil_arprot, axil_arvalid,
      output axil_arready,
      output axil_rdata, axil_rresp, axil_rvalid,
      input  axil_rready
   );
endinterface

// File: rtl/iob2axil.sv
// IOb-slave to AXI4-Lite-master bridge, one transaction in flight.
// Every output is a flop, so arst_i clears valids/readies without waiting for a clock.
module iob2axil #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic clk_i,
   input  logic arst_i,
   input  logic cke_i,
   iob2axil_if.slave bus,
   output logic err_o
);
   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA} state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] wdata_r;
   logic [STRB_W-1:0] wstrb_r;
   logic [DATA_W-1:0] rdata_r;
   logic              ready_r, rvalid_r, err_r;
   logic              aw_pend, w_pend, bready_r, arvalid_r, rready_r;
   logic              aw_left, w_left;

   // AW and W retire independently; WADDR is left once neither is outstanding.
   assign aw_left = aw_pend & ~bus.axil_awready;
   assign w_left  = w_pend & ~bus.axil_wready;

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state     <= IDLE;
         addr_r    <= '0;
         wdata_r   <= '0;
         wstrb_r   <= '0;
         rdata_r   <= '0;
         ready_r   <= 1'b1;
         rvalid_r  <= 1'b0;
         err_r     <= 1'b0;
         aw_pend   <= 1'b0;
         w_pend    <= 1'b0;
         bready_r  <= 1'b0;
         arvalid_r <= 1'b0;
         rready_r  <= 1'b0;
      end else if (cke_i) begin
         rvalid_r <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.iob_avalid) begin
                  addr_r  <= bus.iob_addr;
                  wdata_r <= bus.iob_wdata;
                  wstrb_r <= bus.iob_wstrb;
                  ready_r <= 1'b0;
                  if (|bus.iob_wstrb) begin
                     state   <= WADDR;
                     aw_pend <= 1'b1;
                     w_pend  <= 1'b1;
                  end else begin
                     state     <= RADDR;
                     arvalid_r <= 1'b1;
                  end
               end
            end
            WADDR: begin
               aw_pend <= aw_left;
               w_pend  <= w_left;
               if (!aw_left && !w_left) begin
                  state    <= WRESP;
                  bready_r <= 1'b1;
               end
            end
            WRESP: begin
               if (bus.axil_bvalid) begin
                  state    <= IDLE;
                  bready_r <= 1'b0;
                  ready_r  <= 1'b1;
                  if (bus.axil_bresp != 2'b00) err_r <= 1'b1;
               end
            end
            RADDR: begin
               if (bus.axil_arready) begin
                  state     <= RDATA;
                  arvalid_r <= 1'b0;
                  rready_r  <= 1'b1;
               end
            end
            RDATA: begin
               // data is handed back even when rresp flags an error
               if (bus.axil_rvalid) begin
                  state    <= IDLE;
                  rready_r <= 1'b0;
                  rdata_r  <= bus.axil_rdata;
                  rvalid_r <= 1'b1;
                  ready_r  <= 1'b1;
                  if (bus.axil_rresp != 2'b00) err_r <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.iob_ready    = ready_r;
   assign bus.iob_rvalid   = rvalid_r;
   assign bus.iob_rdata    = rdata_r;
   assign bus.axil_awaddr  = addr_r;
   assign bus.axil_awprot  = 3'b000;
   assign bus.axil_awvalid = aw_pend;
   assign bus.axil_wdata   = wdata_r;
   assign bus.axil_wstrb   = wstrb_r;
   assign bus.axil_wvalid  = w_pend;
   assign bus.axil_bready  = bready_r;
   assign bus.axil_araddr  = addr_r;
   assign bus.axil_arprot  = 3'b000;
   assign bus.axil_arvalid = arvalid_r;
   assign bus.axil_rready  = rready_r;
   assign err_o            = err_r;
endmodule

// File: tb/tb_iob2axil.sv
// Directed bench for iob2axil: IOb initiator tasks plus a delay-configurable AXI-Lite memory target.
module tb_iob2axil;
   logic clk, arst, cke, err;

   iob2axil_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   iob2axil #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk_i (clk),
      .arst_i(arst),
      .cke_i (cke),
      .bus   (bus),
      .err_o (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- AXI-Lite target model ----------------
   int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
   logic [1:0] b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
   int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, viol = 0;
   logic [31:0] aw_addr, w_data, ar_addr;
   logic [3:0]  w_strb;
   logic [31:0] mem [logic [31:0]];
   logic [32:0] axi_log [$];
   int  aw_c, w_c, b_c, ar_c, r_c;
   bit  aw_done, w_done, ar_done;
   bit  hs_aw, hs_w, hs_b, hs_ar, hs_r;
   bit  awv_q, wv_q, arv_q;

   initial begin
      logic [31:0] word;
      bus.axil_awready = 0; bus.axil_wready = 0; bus.axil_bvalid = 0; bus.axil_bresp = 0;
      bus.axil_arready = 0; bus.axil_rvalid = 0; bus.axil_rdata = 0; bus.axil_rresp = 0;
      {aw_c, w_c, b_c, ar_c, r_c} = '0;
      forever begin
         @(negedge clk);
         if (arst) begin
            bus.axil_awready = 0; bus.axil_wready = 0; bus.axil_bvalid = 0;
            bus.axil_arready = 0; bus.axil_rvalid = 0;
            {aw_c, w_c, b_c, ar_c, r_c} = '0;
            {aw_done, w_done, ar_done, hs_aw, hs_w, hs_b, hs_ar, hs_r, awv_q, wv_q, arv_q} = '0;
         end else begin
            // retire the handshakes taken on the previous rising edge
            if (hs_aw) begin aw_done = 1; bus.axil_awready = 0; aw_c = 0; end
            if (hs_w)  begin w_done = 1;  bus.axil_wready = 0;  w_c = 0;  end
            if (hs_b)  begin bus.axil_bvalid = 0; aw_done = 0; w_done = 0; b_c = 0; end
            if (hs_ar) begin ar_done = 1; bus.axil_arready = 0; ar_c = 0; end
            if (hs_r)  begin bus.axil_rvalid = 0; ar_done = 0; r_c = 0; end
            if ((awv_q && !hs_aw && !bus.axil_awvalid) || (wv_q && !hs_w && !bus.axil_wvalid) ||
                (arv_q && !hs_ar && !bus.axil_arvalid)) viol++;
            if (bus.axil_bready && !(aw_done && w_done)) viol++;
            if (bus.axil_rready && !ar_done) viol++;
            if (bus.axil_awvalid && !aw_done) begin
               if (aw_c >= aw_dly) bus.axil_awready = 1; else aw_c++;
            end
            if (bus.axil_wvalid && !w_done) begin
               if (w_c >= w_dly) bus.axil_wready = 1; else w_c++;
            end
            if (bus.axil_arvalid && !ar_done) begin
               if (ar_c >= ar_dly) bus.axil_arready = 1; else ar_c++;
            end
            if (aw_done && w_done && !bus.axil_bvalid) begin
               if (b_c >= b_dly) begin
                  word = mem.exists(aw_addr) ? mem[aw_addr] : 32'h0;
                  for (int b = 0; b < 4; b++) if (w_strb[b]) word[8*b +: 8] = w_data[8*b +: 8];
                  mem[aw_addr] = word;
                  bus.axil_bvalid = 1; bus.axil_bresp = b_resp_cfg;
               end else b_c++;
            end
            if (ar_done && !bus.axil_rvalid) begin
               if (r_c >= r_dly) begin
                  bus.axil_rvalid = 1; bus.axil_rresp = r_resp_cfg;
                  bus.axil_rdata  = mem.exists(ar_addr) ? mem[ar_addr] : 32'h0;
               end else r_c++;
            end
            hs_aw = bus.axil_awvalid && bus.axil_awready;
            hs_w  = bus.axil_wvalid && bus.axil_wready;
            hs_b  = bus.axil_bvalid && bus.axil_bready;
            hs_ar = bus.axil_arvalid && bus.axil_arready;
            hs_r  = bus.axil_rvalid && bus.axil_rready;
            if (hs_aw) begin n_aw++; aw_addr = bus.axil_awaddr; axi_log.push_back({1'b1, bus.axil_awaddr}); end
            if (hs_w)  begin n_w++; w_data = bus.axil_wdata; w_strb = bus.axil_wstrb; end
            if (hs_b)  n_b++;
            if (hs_ar) begin n_ar++; ar_addr = bus.axil_araddr; axi_log.push_back({1'b0, bus.axil_araddr}); end
            if (hs_r)  n_r++;
            awv_q = bus.axil_awvalid; wv_q = bus.axil_wvalid; arv_q = bus.axil_arvalid;
         end
      end
   end

   // ---------------- IOb initiator ----------------
   // occ = cycles from acceptance until iob_ready returns; rd/rv sampled in that cycle.
   task automatic iob_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int cke_hold, output int occ, output logic [31:0] rd, output logic rv);
      int n;
      @(negedge clk);
      bus.iob_avalid = 1; bus.iob_addr = a; bus.iob_wdata = d; bus.iob_wstrb = s;
      n = 0;
      while (!bus.iob_ready && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) check("accept_timeout", 0, 1);
      @(negedge clk);
      bus.iob_avalid = 0;
      occ = 1;
      while (!bus.iob_ready && occ < 200) begin @(negedge clk); occ++; end
      if (occ >= 200) check("done_timeout", 0, 1);
      rv = bus.iob_rvalid; rd = bus.iob_rdata;
      if (cke_hold > 0) begin
         cke = 0;
         repeat (cke_hold) begin @(negedge clk); check("cke_hold_rvalid", bus.iob_rvalid, 1); end
         cke = 1;
      end
      @(negedge clk);
      check("rvalid_one_cycle", bus.iob_rvalid, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int occ, na, nw, nr, k, cyc;
      logic [31:0] rd;
      logic rv;
      logic [31:0] b2b_addr [3];
      logic [3:0]  b2b_strb [3];

      arst = 1; cke = 1;
      bus.iob_avalid = 0; bus.iob_addr = 0; bus.iob_wdata = 0; bus.iob_wstrb = 0;
      repeat (2) @(negedge clk);
      arst = 0;

      // reset state
      check("rst_ready", bus.iob_ready, 1);
      check("rst_rvalid", bus.iob_rvalid, 0);
      check("rst_rdata", bus.iob_rdata, 0);
      check("rst_err", err, 0);
      check("rst_valids", {bus.axil_awvalid, bus.axil_wvalid, bus.axil_arvalid}, 0);
      check("rst_readies", {bus.axil_bready, bus.axil_rready}, 0);
      check("rst_addr", bus.axil_awaddr, 0);
      check("rst_wdata", bus.axil_wdata, 0);
      check("rst_wstrb", bus.axil_wstrb, 0);

      // zero-wait write
      na = n_aw; nw = n_w;
      iob_xfer(32'h100, 32'hDEADBEEF, 4'hF, 0, occ, rd, rv);
      check("wr_occupancy", occ, 3);
      check("wr_no_rvalid", rv, 0);
      check("wr_one_aw", n_aw - na, 1);
      check("wr_one_w", n_w - nw, 1);
      check("wr_awaddr", aw_addr, 32'h100);
      check("wr_wdata", w_data, 32'hDEADBEEF);
      check("wr_wstrb", w_strb, 4'hF);
      check("wr_err", err, 0);

      // slow read, with cke freezing the rvalid pulse for two cycles
      mem[32'h200] = 32'h12345678;
      ar_dly = 5; r_dly = 5; nr = n_ar;
      iob_xfer(32'h200, 32'h0, 4'h0, 2, occ, rd, rv);
      check("rd_slow_occupancy", occ, 13);
      check("rd_slow_rvalid", rv, 1);
      check("rd_slow_rdata", rd, 32'h12345678);
      check("rd_slow_one_ar", n_ar - nr, 1);
      check("rd_slow_araddr", ar_addr, 32'h200);
      ar_dly = 0; r_dly = 0;

      // W three cycles ahead of AW, then AW ahead of W
      aw_dly = 3; w_dly = 0;
      iob_xfer(32'h108, 32'h11223344, 4'h3, 0, occ, rd, rv);
      check("w_first_occupancy", occ, 6);
      check("w_first_wstrb", w_strb, 4'h3);
      aw_dly = 0; w_dly = 3;
      iob_xfer(32'h10C, 32'h55667788, 4'hC, 0, occ, rd, rv);
      check("aw_first_occupancy", occ, 6);
      check("aw_first_awaddr", aw_addr, 32'h10C);
      w_dly = 0;
      check("order_protocol", viol, 0);

      // error responses: sticky err, read data still delivered
      b_resp_cfg = 2'b10;
      iob_xfer(32'h110, 32'h0000_00AA, 4'h1, 0, occ, rd, rv);
      check("bresp_err", err, 1);
      b_resp_cfg = 2'b00; r_resp_cfg = 2'b11;
      iob_xfer(32'h200, 32'h0, 4'h0, 0, occ, rd, rv);
      check("rresp_rdata", rd, 32'h12345678);
      check("rresp_rvalid", rv, 1);
      check("rresp_err", err, 1);
      r_resp_cfg = 2'b00;
      iob_xfer(32'h200, 32'h0, 4'h0, 0, occ, rd, rv);
      check("err_sticky", err, 1);

      // back-to-back write, read, read with avalid held high
      mem[32'h304] = 32'h0BADC0DE;
      axi_log.delete();
      b2b_addr[0] = 32'h300; b2b_strb[0] = 4'hF;
      b2b_addr[1] = 32'h300; b2b_strb[1] = 4'h0;
      b2b_addr[2] = 32'h304; b2b_strb[2] = 4'h0;
      @(negedge clk);
      bus.iob_avalid = 1; bus.iob_addr = b2b_addr[0]; bus.iob_wdata = 32'hCAFEF00D; bus.iob_wstrb = b2b_strb[0];
      k = 0; cyc = 0;
      while (k < 3 && cyc < 200) begin
         if (bus.iob_ready) begin
            if (k == 2) begin
               check("b2b_rd1_same_cycle", bus.iob_rvalid, 1);
               check("b2b_rd1_rdata", bus.iob_rdata, 32'hCAFEF00D);
            end
            k++;
            @(negedge clk);
            if (k < 3) begin
               bus.iob_addr = b2b_addr[k]; bus.iob_wstrb = b2b_strb[k]; bus.iob_wdata = 32'h0;
            end else bus.iob_avalid = 0;
         end else @(negedge clk);
         cyc++;
      end
      check("b2b_all_accepted", k, 3);
      cyc = 0;
      while (!bus.iob_ready && cyc < 200) begin @(negedge clk); cyc++; end
      check("b2b_rd2_rvalid", bus.iob_rvalid, 1);
      check("b2b_rd2_rdata", bus.iob_rdata, 32'h0BADC0DE);
      check("b2b_n_axi", axi_log.size(), 3);
      if (axi_log.size() == 3) begin
         check("b2b_axi0", axi_log[0], {1'b1, 32'h300});
         check("b2b_axi1", axi_log[1], {1'b0, 32'h300});
         check("b2b_axi2", axi_log[2], {1'b0, 32'h304});
      end
      @(negedge clk);

      // asynchronous reset in WADDR
      aw_dly = 50; w_dly = 50;
      @(negedge clk);
      bus.iob_avalid = 1; bus.iob_addr = 32'h400; bus.iob_wdata = 32'h1; bus.iob_wstrb = 4'hF;
      @(negedge clk);
      bus.iob_avalid = 0;
      check("rst_pre_awvalid", bus.axil_awvalid, 1);
      #2 arst = 1;
      #1;
      check("rst_async_valids", {bus.axil_awvalid, bus.axil_wvalid}, 2'b00);
      check("rst_async_ready", bus.iob_ready, 1);
      @(negedge clk);
      @(negedge clk);
      aw_dly = 0; w_dly = 0;
      arst = 0;
      check("rst_post_ready", bus.iob_ready, 1);
      check("rst_post_err", err, 0);
      iob_xfer(32'h200, 32'h0, 4'h0, 0, occ, rd, rv);
      check("rst_post_rd_occupancy", occ, 3);
      check("rst_post_rd_rdata", rd, 32'h12345678);
      check("rst_post_rd_rvalid", rv, 1);
      check("protocol_total", viol, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
